quadrature_decoder: RTL and testbench
=====================================

# quadrature_decoder

Decodes a two-phase quadrature encoder (A/B) into direction-qualified step events and an N-bit position register. It is the receive end of the up/down-count interface: it turns the external Gray-coded A/B signals back into the `step`/`dir` information that our counters consume, and it keeps its own position count. It sits at the chip boundary, behind the pad ring, and feeds motor/position control logic. Both phase inputs are asynchronous to `clk`.

## Interface
- `N`, 16: position width in bits.
- `FILT_LEN`, 4: number of consecutive stable cycles required before a new input level is accepted. Only used when `QDEC_FILTER_EN` is defined. Legal range 1..255.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `qa` input 1: encoder phase A, asynchronous.
- `qb` input 1: encoder phase B, asynchronous.
- `clear` input 1: synchronous clear of `position`.
- `load` input 1: synchronous load of `position` from `load_val`.
- `load_val` input N: value used by `load`.
- `err_clr` input 1: clears `err`.
- `step` output 1: one-cycle pulse for each legal A/B transition.
- `dir` output 1: direction of the latest step; 1 = forward (up), 0 = reverse.
- `position` output N: signed-agnostic position count, modulo 2^N.
- `err` output 1: sticky illegal-transition flag.
- `ready` output 1: high once the FSM is in RUN.

## Operation
- Each phase passes through a 2-flop synchronizer. With `QDEC_FILTER_EN` defined, it then passes through the glitch filter.
- FSM states:
  - INIT: entered on reset. Waits for the input pipeline to fill (`INIT_CYC` edges). On exit, the previous-AB register `prev_ab` is loaded with the current accepted AB, with no decode, and the FSM moves to RUN. This suppresses false steps or errors when the inputs are not 00 at reset release.
  - RUN: every cycle the current accepted AB (`cur_ab`) is compared with `prev_ab`, then `prev_ab <= cur_ab`. RUN persists until reset.
- Decode (4x resolution):
  - Forward sequence is 00→01→11→10→00: `step`=1, `dir`=1, position +1.
  - The exact reverse of that sequence: `step`=1, `dir`=0, position −1.
  - No change: no action.
  - Both bits change (00↔11 or 01↔10): `err` is set, `step`=0, `position` and `dir` are unchanged.
- Arithmetic is modulo 2^N, so all-ones +1 gives 0 and 0 −1 gives all-ones. No saturation.
- `position` priority, highest first: `clear` > `load` > decoded step.
  - When a step coincides with `clear` or `load`, `step` and `dir` still report the event, but `position` takes 0 or `load_val`.
- `err` is set and cleared as follows:
  - If a set condition and `err_clr` occur in the same cycle, set wins.
  - `err_clr` has no effect on `position`.
- `clear`, `load` and `err_clr` are honoured in INIT as well as RUN.

## Timing
- Reset values: `step`=0, `dir`=0, `position`=0, `err`=0, `ready`=0. Synchronizers, filter and `prev_ab` reset to 0.
- Asserting `reset_n` mid-operation returns immediately to INIT with all reset values. There is no partial state.
- `INIT_CYC` is 2 without the filter and 2+`FILT_LEN` with it. `ready` rises on the edge where the FSM enters RUN.
- Latency without the filter: take E0 as the first rising edge that samples a new `qa`/`qb` level. `step`, `dir` and `position` update on edge E2.
- Latency with the filter: updates occur on edge E2+`FILT_LEN`.
- `clear`/`load` take effect on the edge at which they are sampled (1-cycle latency).
- `step` is registered and lasts exactly one cycle per transition.
- Maximum trackable input rate is one AB change per 3 clocks, or per `FILT_LEN`+1 clocks with the filter. Faster input produces `err` or missed counts.

## Configuration
- `QDEC_FILTER_EN` defined:
  - Per channel there is a counter that tracks how many consecutive cycles the synchronized level has differed from the accepted level.
  - The new level is accepted when the count reaches `FILT_LEN`.
  - Any return to the accepted level resets the count, so pulses shorter than `FILT_LEN` cycles are ignored.
  - In INIT, the accepted level follows the synchronized level every cycle.
- `QDEC_FILTER_EN` not defined: the accepted level is the synchronizer output directly. No filter logic is present and `FILT_LEN` is ignored.

## Structure
- Package `qdec_pkg` holds:
  - `typedef logic [1:0] ab_t`;
  - `typedef enum logic {QDEC_INIT, QDEC_RUN} qdec_state_e`;
  - constants `AB_00`, `AB_01`, `AB_11`, `AB_10`.
- Sub-module `qdec_sync_filter`: a single-bit synchronizer plus the optional filter, instantiated once per phase. Its parameter `FILT_LEN` and an `init` input force the accepted level to follow the synchronized level.

## Test plan
- Reset release with qa=qb=1 held: `ready` rises after `INIT_CYC` edges; `err`=0, `step` never pulses, `position`=0.
- Forward sequence 00→01→11→10→00 repeated twice, each level held 10 cycles: 8 `step` pulses with `dir`=1; `position`=8, each update at E2 (no filter).
- N=8, `load_val`=8'h01 loaded, then 2 reverse transitions: `position`=8'h00 then 8'hFF; `dir`=0.
- Jump 00→11: `err`=1, `position` unchanged. `err_clr` asserted in the same cycle as a second 01→10 jump: `err` stays 1. `err_clr` alone afterwards: `err`=0.
- Forward step colliding with `load` (`load_val`=16'h1234) and, separately, with `clear`: `step`=1, `dir`=1, `position`=16'h1234 and 0 respectively.
- With `QDEC_FILTER_EN`, `FILT_LEN`=4: a 3-cycle glitch on `qa` gives no `step`; a 4-cycle stable change gives a `step` at E6. Asserting `reset_n` mid-sequence zeroes all outputs and re-enters INIT.

Source files
------------

// File: rtl/qdec_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package qdec_pkg;

    typedef logic [1:0] ab_t;

    typedef enum logic {
        QDEC_INIT,
        QDEC_RUN
    } qdec_state_e;

    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_01 = 2'b01;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_10 = 2'b10;

    // Successor of an AB level in the forward (count-up) direction.
    function automatic ab_t qdec_fwd_next(input ab_t ab);
        case (ab)
            AB_00:   return AB_01;
            AB_01:   return AB_11;
            AB_11:   return AB_10;
            default: return AB_00;
        endcase
    endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// One encoder phase: 2-flop synchronizer, plus a stability filter when QDEC_FILTER_EN is defined.
// acc_next_o is the level acc_o will hold after the next edge.
module qdec_sync_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    input  logic init_i,
    output logic acc_o,
    output logic acc_next_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int unsigned CNT_W = 8;

    logic             acc_q;
    logic             acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles the synchronized level disagrees with the accepted one.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (init_i) begin
            acc_d = sync_q[1];
            cnt_d = '0;
        end else if (sync_q[1] == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            acc_d = sync_q[1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o      = acc_q;
    assign acc_next_o = acc_d;
`else
    assign acc_o      = sync_q[1];
    assign acc_next_o = sync_q[0];

    // init and FILT_LEN only matter when the filter is built.
    logic unused_cfg;
    assign unused_cfg = init_i | (FILT_LEN == 0);
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: 4x step/dir events, modulo-2^N position, sticky illegal-jump flag.
// Optional input glitch filter enabled by defining QDEC_FILTER_EN.
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         qa,
    input  logic         qb,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         err_clr,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] position,
    output logic         err,
    output logic         ready
);

`ifdef QDEC_FILTER_EN
    localparam int unsigned INIT_CYC = 2 + FILT_LEN;
`else
    localparam int unsigned INIT_CYC = 2;
`endif
    localparam int unsigned CNT_W = 9;

    qdec_state_e      state_q;
    logic [CNT_W-1:0] init_cnt_q;
    ab_t              prev_ab_q;
    logic             step_q;
    logic             dir_q;
    logic [N-1:0]     pos_q;
    logic             err_q;
    logic             ready_q;

    logic acc_a, acc_b, nxt_a, nxt_b;
    logic init_c;
    ab_t  cur_ab;
    ab_t  nxt_ab;
    logic fwd_c, rev_c, jump_c;

    assign init_c = (state_q == QDEC_INIT);

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_i        (qa),
        .init_i     (init_c),
        .acc_o      (acc_a),
        .acc_next_o (nxt_a)
    );

    qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_i        (qb),
        .init_i     (init_c),
        .acc_o      (acc_b),
        .acc_next_o (nxt_b)
    );

    assign cur_ab = {acc_a, acc_b};
    assign nxt_ab = {nxt_a, nxt_b};

    // Classify the accepted AB change; only meaningful once running.
    always_comb begin
        fwd_c  = 1'b0;
        rev_c  = 1'b0;
        jump_c = 1'b0;
        if (state_q == QDEC_RUN) begin
            fwd_c  = (cur_ab == qdec_fwd_next(prev_ab_q));
            rev_c  = (prev_ab_q == qdec_fwd_next(cur_ab));
            jump_c = ((cur_ab ^ prev_ab_q) == 2'b11);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= QDEC_INIT;
            init_cnt_q <= '0;
            prev_ab_q  <= AB_00;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            pos_q      <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;

            // Prime prev_ab with the settled input level so the first RUN cycle sees no change.
            if (state_q == QDEC_INIT) begin
                if (init_cnt_q == CNT_W'(INIT_CYC - 1)) begin
                    state_q   <= QDEC_RUN;
                    ready_q   <= 1'b1;
                    prev_ab_q <= nxt_ab;
                end else begin
                    init_cnt_q <= init_cnt_q + CNT_W'(1);
                end
            end else begin
                prev_ab_q <= cur_ab;
                if (fwd_c || rev_c) begin
                    step_q <= 1'b1;
                    dir_q  <= fwd_c;
                end
            end

            if (clear) begin
                pos_q <= '0;
            end else if (load) begin
                pos_q <= load_val;
            end else if (fwd_c) begin
                pos_q <= pos_q + N'(1);
            end else if (rev_c) begin
                pos_q <= pos_q - N'(1);
            end

            if (jump_c) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign position = pos_q;
    assign err      = err_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (N=16 and N=8 instances) with a Gray-index reference model.
module tb_quadrature_decoder;

    localparam int unsigned FL = 4;
`ifdef QDEC_FILTER_EN
    localparam int unsigned LAT = 2 + FL;
`else
    localparam int unsigned LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        qa = 1'b1;
    logic        qb = 1'b1;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] load_val16 = '0;
    logic [7:0]  load_val8 = '0;

    logic        step16, dir16, err16, ready16;
    logic [15:0] pos16;
    logic        step8, dir8, err8, ready8;
    logic [7:0]  pos8;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    bit cmp_en = 1'b1;

    quadrature_decoder #(.N(16), .FILT_LEN(FL)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .qa(qa), .qb(qb),
        .clear(clear), .load(load), .load_val(load_val16), .err_clr(err_clr),
        .step(step16), .dir(dir16), .position(pos16), .err(err16), .ready(ready16)
    );

    quadrature_decoder #(.N(8), .FILT_LEN(FL)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .qa(qa), .qb(qb),
        .clear(clear), .load(load), .load_val(load_val8), .err_clr(err_clr),
        .step(step8), .dir(dir8), .position(pos8), .err(err8), .ready(ready8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position of an AB level around the Gray cycle 00,01,11,10.
    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Reference model: the level decoded at an edge is the input sampled LAT edges earlier.
    int          n;
    logic [1:0]  hist[$];
    logic [1:0]  m_prev;
    logic        m_step, m_dir, m_err, m_ready;
    logic [15:0] m_pos16;
    logic [7:0]  m_pos8;

    always @(posedge clk or negedge reset_n) begin
        logic [1:0] lvl;
        int d;
        if (!reset_n) begin
            n = 0; hist.delete(); m_prev = 2'b00;
            m_step = 0; m_dir = 0; m_err = 0; m_ready = 0; m_pos16 = '0; m_pos8 = '0;
        end else begin
            d = 0;
            m_step = 0;
            hist.push_back({qa, qb});
            if (hist.size() > LAT + 1) void'(hist.pop_front());
            n++;
            if (n == int'(LAT)) begin
                m_ready = 1;
                m_prev = hist[$];
            end else if (n > int'(LAT)) begin
                lvl = hist[0];
                d = (gidx(lvl) - gidx(m_prev) + 4) % 4;
                m_prev = lvl;
            end
            if (d == 1 || d == 3) begin
                m_step = 1;
                m_dir = (d == 1);
            end
            if (clear) begin
                m_pos16 = '0; m_pos8 = '0;
            end else if (load) begin
                m_pos16 = load_val16; m_pos8 = load_val8;
            end else if (d == 1) begin
                m_pos16 = m_pos16 + 16'd1; m_pos8 = m_pos8 + 8'd1;
            end else if (d == 3) begin
                m_pos16 = m_pos16 - 16'd1; m_pos8 = m_pos8 - 8'd1;
            end
            if (d == 2) m_err = 1;
            else if (err_clr) m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && step16) step_cnt++;
        if (cmp_en) begin
            chk("m_step16", step16, m_step);
            chk("m_dir16", dir16, m_dir);
            chk("m_pos16", pos16, m_pos16);
            chk("m_err16", err16, m_err);
            chk("m_ready16", ready16, m_ready);
            chk("m_step8", step8, m_step);
            chk("m_dir8", dir8, m_dir);
            chk("m_pos8", pos8, m_pos8);
            chk("m_err8", err8, m_err);
            chk("m_ready8", ready8, m_ready);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] ab);
        qa = ab[1];
        qb = ab[0];
    endtask

    logic [1:0] fwd_seq [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    initial begin
        // Reset with both phases high: no steps, no error after release.
        cyc(3);
        chk("rst_ready", ready16, 0);
        chk("rst_pos", pos16, 0);
        chk("rst_step", step16, 0);
        chk("rst_err", err16, 0);
        reset_n = 1'b1;
        cyc(1);
        chk("init_ready_early", ready16, 0);
        cyc(LAT - 1);
        chk("init_ready", ready16, 1);
        step_cnt = 0;
        cyc(10);
        chk("init11_steps", step_cnt, 0);
        chk("init11_pos", pos16, 0);
        chk("init11_err", err16, 0);

        // Restart from 00.
        reset_n = 1'b0;
        set_ab(2'b00);
        cyc(3);
        reset_n = 1'b1;
        cyc(LAT + 3);

        // Two forward cycles; first transition checked for latency.
        step_cnt = 0;
        set_ab(fwd_seq[0]);
        cyc(LAT);
        chk("lat_before", step16, 0);
        cyc(1);
        chk("lat_step", step16, 1);
        chk("lat_pos", pos16, 1);
        cyc(9);
        for (int i = 1; i < 8; i++) begin
            set_ab(fwd_seq[i]);
            cyc(10);
        end
        chk("fwd_pos16", pos16, 8);
        chk("fwd_pos8", pos8, 8);
        chk("fwd_steps", step_cnt, 8);
        chk("fwd_dir", dir16, 1);

        // Load 1, then reverse twice through zero.
        load_val16 = 16'h0001; load_val8 = 8'h01;
        load = 1'b1; cyc(1); load = 1'b0;
        chk("load_pos8", pos8, 8'h01);
        set_ab(2'b10); cyc(10);
        chk("rev1_pos8", pos8, 8'h00);
        set_ab(2'b11); cyc(10);
        chk("rev2_pos8", pos8, 8'hFF);
        chk("rev2_pos16", pos16, 16'hFFFF);
        chk("rev_dir", dir8, 0);

        // Forward to 00 then illegal jump to 11.
        set_ab(2'b10); cyc(10);
        set_ab(2'b00); cyc(10);
        chk("pre_jump_pos", pos16, 16'h0001);
        set_ab(2'b11); cyc(10);
        chk("jump_err", err16, 1);
        chk("jump_pos", pos16, 16'h0001);
        set_ab(2'b01); cyc(10);
        chk("rev_after_jump", pos16, 16'h0000);

        // Second jump 01->10 with err_clr on the decode edge: set wins.
        set_ab(2'b10); cyc(LAT);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        chk("setwins_err", err16, 1);
        chk("setwins_pos", pos16, 0);
        cyc(9);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        chk("errclr_err", err16, 0);

        // Step colliding with load, then with clear.
        load_val16 = 16'h1234; load_val8 = 8'h34;
        set_ab(2'b00); cyc(LAT);
        load = 1'b1; cyc(1); load = 1'b0;
        chk("ldcol_step", step16, 1);
        chk("ldcol_dir", dir16, 1);
        chk("ldcol_pos", pos16, 16'h1234);
        cyc(9);
        set_ab(2'b01); cyc(LAT);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("clrcol_step", step16, 1);
        chk("clrcol_dir", dir16, 1);
        chk("clrcol_pos", pos16, 0);
        cyc(9);

        // Wrap all-ones + 1.
        load_val16 = 16'hFFFF; load_val8 = 8'hFF;
        load = 1'b1; cyc(1); load = 1'b0;
        set_ab(2'b11); cyc(10);
        chk("wrap_pos16", pos16, 0);
        chk("wrap_pos8", pos8, 0);

`ifdef QDEC_FILTER_EN
        // 3-cycle glitch is rejected; a held change steps at E(2+FL).
        cmp_en = 1'b0;
        step_cnt = 0;
        set_ab(2'b01); cyc(3);
        set_ab(2'b11); cyc(15);
        chk("glitch_steps", step_cnt, 0);
        set_ab(2'b10); cyc(LAT);
        chk("filt_before", step16, 0);
        cyc(1);
        chk("filt_step", step16, 1);
        cyc(10);
`endif

        // Reset asserted mid-transition clears everything immediately.
        load_val16 = 16'hABCD; load_val8 = 8'hCD;
        load = 1'b1; cyc(1); load = 1'b0;
        set_ab({~qa, qb}); cyc(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_step", step16, 0);
        chk("midrst_dir", dir16, 0);
        chk("midrst_pos", pos16, 0);
        chk("midrst_err", err16, 0);
        chk("midrst_ready", ready16, 0);
        cyc(3);
        reset_n = 1'b1;
        cmp_en = 1'b1;
        cyc(LAT + 3);
        chk("post_rst_ready", ready16, 1);
        chk("post_rst_pos", pos16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
